mat_vect_mult_stream: RTL and testbench
=======================================

# mat_vect_mult_stream

Streaming, parametrised matrix-vector multiplier. It computes y = A·b for an M×N matrix A and an N-element vector b, one matrix column and one vector element per accepted beat. Results leave through a valid/ready serial port, one row per beat, with double buffering so the next product accumulates while the previous one drains. It is the next-generation replacement for the fixed N×N, shift-enable matrix-vector block in the FPGA lab datapath.

## Interface
- M, default 3: rows of A, which is also the number of results per product.
- N, default 3: columns of A, which is also the length of b (beats per product).
- DW, default 8: element width of A and b.
- SIGNED, default 0: 0 treats operands as unsigned; 1 treats them as two's complement.
- RW, derived as 2*DW + $clog2(N): result width (exact, no overflow possible).
- RIW, derived as max(1, $clog2(M)): width of the row index.

Ports:
- clk  in  1  the single clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous; abandons the partial accumulation.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a_col  in  DW × [0:M-1] (unpacked)  column k of A; a_col[i] = A[i][k].
- b_elem  in  DW  b[k].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- result  out  RW  y[result_row].
- result_row  out  RIW  row index of the current result.
- out_last  out  1  high on row M-1.

## Operation
- Accumulator bank: M accumulators acc[i] of RW bits, plus beat counter k in 0..N-1.
  - On an accepted beat: acc[i] += a_col[i]*b_elem. The product is DW×DW→2*DW, sign- or zero-extended per SIGNED.
  - k increments on each accepted beat and wraps to 0 after N-1.
- Completion: the accepted beat with k==N-1 completes a product.
  - If the output bank is free at that edge, it loads acc+final products and the accumulators clear.
  - Otherwise the completed sums are held and the block sets acc_full.
- in_ready = !acc_full && !clr.
- Output bank: M registers plus a row index r.
  - out_valid = bank_valid.
  - result = bank[r], result_row = r, out_last = (r==M-1).
  - On out_valid && out_ready: r increments. On the last row, bank_valid clears and r returns to 0.
- Bank free: true when !bank_valid, or when the last row is being accepted in this same cycle. Same-cycle reload is required, with no bubble.
- acc_full drain: when acc_full and the bank is free, the bank loads the held sums, the accumulators clear and acc_full clears.
- clr: zeroes the accumulators and k, and clears acc_full (held sums are discarded). No beat is accepted in a clr cycle. The output bank is unaffected.
- Beats with in_valid low do not change state. in_valid is ignored while in_ready is low.

## Timing
- Reset (rst low) values:
  - out_valid=0, result=0, result_row=0, out_last=0.
  - in_ready=1 (after rst releases, with clr low).
  - acc, k, bank, r and acc_full all 0.
- Latency: last beat accepted at edge t → out_valid high after edge t, with row 0. Row i is presented in cycle t+1+i under continuous out_ready.
- Throughput: one product per max(N, M) cycles sustained, with no idle cycles between vectors when out_ready is held high.
- Stall: acc_full holds in_ready low until the bank frees. Input reopens on the cycle after the held sums load.
- Output stability: result, result_row and out_last stay stable while out_valid && !out_ready.
- Reset mid-product or mid-drain: all state is lost immediately and asynchronously. No partial output is emitted after release.
- N=1: every accepted beat completes a product. M=1: every output beat is out_last.

## Test plan
1. **Basic product.** M=2, N=3, DW=8, unsigned, out_ready=1. Send columns (1,4)/b=7, (2,5)/b=8, (3,6)/b=9 → out_valid one cycle after the 3rd beat. Expected output: row0=50, then row1=122 with out_last.
2. **Signed extremes.** SIGNED=1, M=2, N=3. All a=-128, b=-128 → both rows are 49152. Then a=127, b=-128 → -48768. Unsigned build with all 255 → 195075, no overflow at RW=18.
3. **Backpressure.** out_ready=0, stream three vectors back to back:
   - Vector 1 loads the bank.
   - Vector 2 sets acc_full, and in_ready drops after its 3rd beat; vector 3 stalls.
   - Raise out_ready: the bank drains, vector 2 loads, in_ready returns, and vector 3 completes.
   - All results match the model and arrive in order.
4. **Same-cycle reload.** With out_ready=1 and a continuous stream, N=M=3: out_valid stays high with no gap across vector boundaries, and result_row goes 0,1,2,0,1,2.
5. **clr mid-product.** Assert clr after 2 of 3 beats; in_ready=0 during the clr cycle. Resend a full vector → the result reflects only the new vector. Output already in the bank is unaffected.
6. **Reset mid-operation.** Pull rst low during a drain with out_valid=1 → out_valid=0 immediately and all outputs are 0. After release, one fresh vector yields exactly one correct result set.

Source files
------------

// File: rtl/mat_vect_mult_stream_if.sv
// mat_vect_mult_stream_if: column-in / row-out streaming bus of the matrix-vector multiplier
interface mat_vect_mult_stream_if #(
    parameter int M   = 3,
    parameter int N   = 3,
    parameter int DW  = 8,
    parameter int RW  = 2 * DW + $clog2(N),
    parameter int RIW = (M > 1) ? $clog2(M) : 1
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  a_col [0:M-1];
    logic [DW-1:0]  b_elem;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  result;
    logic [RIW-1:0] result_row;
    logic           out_last;

    modport master (
        output in_valid, a_col, b_elem, out_ready,
        input  in_ready, out_valid, result, result_row, out_last
    );

    modport slave (
        input  in_valid, a_col, b_elem, out_ready,
        output in_ready, out_valid, result, result_row, out_last
    );
endinterface

// File: rtl/mat_vect_mult_stream.sv
// mat_vect_mult_stream: y = A*b, one column of A per input beat, one row of y per output beat, double buffered
module mat_vect_mult_stream #(
    parameter int M      = 3,
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input logic clk,
    input logic rst,
    input logic clr,
    mat_vect_mult_stream_if.slave io
);
    localparam int RW  = 2 * DW + $clog2(N);
    localparam int RIW = (M > 1) ? $clog2(M) : 1;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);
    localparam logic [RIW-1:0] R_LAST = RIW'(M - 1);

    logic [RW-1:0]  acc_q [M];
    logic [RW-1:0]  acc_d [M];
    logic [RW-1:0]  bank_q [M];
    logic [RW-1:0]  bank_d [M];
    logic [RW-1:0]  sum [M];
    logic [KW-1:0]  k_q, k_d;
    logic [RIW-1:0] r_q, r_d;
    logic           acc_full_q, acc_full_d;
    logic           bank_valid_q, bank_valid_d;
    logic           in_fire, out_fire, last_out, bank_free;

    // Operands widened to the full result width; the product modulo 2^RW is then exact because it always fits
    function automatic logic [RW-1:0] ext(input logic [DW-1:0] v);
        return SIGNED ? {{(RW - DW){v[DW-1]}}, v} : {{(RW - DW){1'b0}}, v};
    endfunction

    assign io.in_ready   = !acc_full_q && !clr;
    assign in_fire       = io.in_valid && io.in_ready;
    assign out_fire      = bank_valid_q && io.out_ready;
    assign last_out      = out_fire && (r_q == R_LAST);
    assign bank_free     = !bank_valid_q || last_out;
    assign io.out_valid  = bank_valid_q;
    assign io.result     = bank_q[r_q];
    assign io.result_row = r_q;
    assign io.out_last   = bank_valid_q && (r_q == R_LAST);

    // Accumulator plus this beat's column products
    always_comb begin
        for (int i = 0; i < M; i++) sum[i] = acc_q[i] + ext(io.a_col[i]) * ext(io.b_elem);
    end

    // Next state: output row walk, then clr / held-sum drain / beat accumulation in priority order
    always_comb begin
        acc_d        = acc_q;
        k_d          = k_q;
        acc_full_d   = acc_full_q;
        bank_d       = bank_q;
        bank_valid_d = bank_valid_q;
        r_d          = r_q;
        if (out_fire) begin
            r_d          = last_out ? '0 : r_q + 1'b1;
            bank_valid_d = !last_out;
        end
        if (clr) begin
            acc_d      = '{default: '0};
            k_d        = '0;
            acc_full_d = 1'b0;
        end else if (acc_full_q) begin
            if (bank_free) begin
                bank_d       = acc_q;
                bank_valid_d = 1'b1;
                acc_d        = '{default: '0};
                acc_full_d   = 1'b0;
            end
        end else if (in_fire) begin
            k_d   = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            acc_d = sum;
            if (k_q == K_LAST) begin
                if (bank_free) begin
                    bank_d       = sum;
                    bank_valid_d = 1'b1;
                    acc_d        = '{default: '0};
                end else begin
                    acc_full_d = 1'b1;
                end
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '{default: '0};
            bank_q       <= '{default: '0};
            k_q          <= '0;
            r_q          <= '0;
            acc_full_q   <= 1'b0;
            bank_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            bank_q       <= bank_d;
            k_q          <= k_d;
            r_q          <= r_d;
            acc_full_q   <= acc_full_d;
            bank_valid_q <= bank_valid_d;
        end
    end
endmodule

// File: tb/tb_mat_vect_mult_stream.sv
// tb_mat_vect_mult_stream: unsigned and signed instances on shared stimulus, checked against a product-queue model
module tb_mat_vect_mult_stream;
    localparam int M  = 3;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int LIM = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] a_col [M];
    logic [DW-1:0] b_elem = '0;
    logic          or_dir = 1'b0;
    logic          or_rand = 1'b0;
    logic          rnd_or = 1'b0;
    logic          out_ready;
    int            errs = 0;
    int            checks = 0;

    assign out_ready = or_rand ? rnd_or : or_dir;

    always #5 clk = ~clk;

    mat_vect_mult_stream_if #(.M(M), .N(N), .DW(DW)) if_u ();
    mat_vect_mult_stream_if #(.M(M), .N(N), .DW(DW)) if_s ();

    assign if_u.in_valid  = in_valid;
    assign if_s.in_valid  = in_valid;
    assign if_u.b_elem    = b_elem;
    assign if_s.b_elem    = b_elem;
    assign if_u.out_ready = out_ready;
    assign if_s.out_ready = out_ready;
    for (genvar g = 0; g < M; g++) begin : g_col
        assign if_u.a_col[g] = a_col[g];
        assign if_s.a_col[g] = a_col[g];
    end

    mat_vect_mult_stream #(.M(M), .N(N), .DW(DW), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .clr(clr), .io(if_u)
    );
    mat_vect_mult_stream #(.M(M), .N(N), .DW(DW), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .clr(clr), .io(if_s)
    );

    // Reference: a queue of completed products awaiting output; at most one in the bank and one held
    typedef struct {
        longint u [M];
        longint s [M];
    } prod_t;

    prod_t  q [$];
    prod_t  cur;
    int     mk = 0;
    int     orow = 0;
    bit     m_ok;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each clock edge from the bench's own inputs
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mk = 0;
            orow = 0;
            for (int i = 0; i < M; i++) begin cur.u[i] = 0; cur.s[i] = 0; end
        end else begin
            m_ok = !clr && q.size() < 2;
            if (clr && q.size() == 2) void'(q.pop_back());
            if (out_ready && q.size() > 0) begin
                if (orow == M - 1) begin
                    void'(q.pop_front());
                    orow = 0;
                end else orow++;
            end
            if (clr) begin
                mk = 0;
                for (int i = 0; i < M; i++) begin cur.u[i] = 0; cur.s[i] = 0; end
            end else if (in_valid && m_ok) begin
                for (int i = 0; i < M; i++) begin
                    cur.u[i] += longint'(a_col[i]) * longint'(b_elem);
                    cur.s[i] += longint'($signed(a_col[i])) * longint'($signed(b_elem));
                end
                mk++;
                if (mk == N) begin
                    q.push_back(cur);
                    mk = 0;
                    for (int i = 0; i < M; i++) begin cur.u[i] = 0; cur.s[i] = 0; end
                end
            end
        end
    end

    // Compare both instances against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid_u", if_u.out_valid, 0);
            chk("rst_result_u", if_u.result, 0);
            chk("rst_out_valid_s", if_s.out_valid, 0);
            chk("rst_result_s", if_s.result, 0);
        end else begin
            chk("in_ready_u", if_u.in_ready, !clr && q.size() < 2);
            chk("in_ready_s", if_s.in_ready, !clr && q.size() < 2);
            chk("out_valid_u", if_u.out_valid, q.size() > 0);
            chk("out_valid_s", if_s.out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("result_u", if_u.result, q[0].u[orow]);
                chk("result_s", $signed(if_s.result), q[0].s[orow]);
                chk("row_u", if_u.result_row, orow);
                chk("row_s", if_s.result_row, orow);
                chk("last_u", if_u.out_last, orow == M - 1);
                chk("last_s", if_s.out_last, orow == M - 1);
            end
        end
    end

    // Random out_ready source for the randomized phase
    always @(posedge clk) begin
        #1 rnd_or = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] a0, a1, a2, b);
        int g;
        g = 0;
        in_valid = 1'b1;
        a_col[0] = a0;
        a_col[1] = a1;
        a_col[2] = a2;
        b_elem   = b;
        #1;
        while (!if_u.in_ready && g < LIM) begin
            @(posedge clk);
            #2;
            g++;
        end
        chk("beat_accept_timeout", g >= LIM, 0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic rvec();
        repeat (N) beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic drain();
        int g;
        g = 0;
        or_rand = 1'b0;
        or_dir  = 1'b1;
        while ((q.size() > 0 || if_u.out_valid) && g < LIM) begin
            step();
            g++;
        end
        chk("drain_timeout", g >= LIM, 0);
    endtask

    task automatic wait_valid(input string nm);
        int g;
        g = 0;
        while (!if_u.out_valid && g < LIM) begin
            step();
            g++;
        end
        chk(nm, g >= LIM, 0);
    endtask

    initial begin
        for (int i = 0; i < M; i++) a_col[i] = '0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("reset_in_ready", if_u.in_ready, 1);
        chk("reset_out_valid", if_u.out_valid, 0);
        chk("reset_out_last", if_u.out_last, 0);
        step();

        // Basic product with literal expectations
        or_dir = 1'b1;
        beat(8'd1, 8'd4, 8'd2, 8'd7);
        beat(8'd2, 8'd5, 8'd3, 8'd8);
        beat(8'd3, 8'd6, 8'd1, 8'd9);
        chk("t1_valid", if_u.out_valid, 1);
        chk("t1_row0_u", if_u.result, 50);
        chk("t1_row0_s", $signed(if_s.result), 50);
        chk("t1_row0_idx", if_u.result_row, 0);
        step();
        chk("t1_row1_u", if_u.result, 122);
        chk("t1_row1_last", if_u.out_last, 0);
        step();
        chk("t1_row2_u", if_u.result, 47);
        chk("t1_row2_last", if_u.out_last, 1);
        step();
        chk("t1_done", if_u.out_valid, 0);

        // Signed and unsigned extremes
        repeat (N) beat(8'h80, 8'h80, 8'h80, 8'h80);
        chk("t2_min_u", if_u.result, 49152);
        chk("t2_min_s", $signed(if_s.result), 49152);
        drain();
        repeat (N) beat(8'h7F, 8'h7F, 8'h7F, 8'h80);
        chk("t2_mix_u", if_u.result, 48768);
        chk("t2_mix_s", $signed(if_s.result), -48768);
        drain();
        repeat (N) beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("t2_max_u", if_u.result, 195075);
        chk("t2_max_s", $signed(if_s.result), 3);
        drain();

        // Backpressure: bank full, second vector held, third stalls
        or_dir = 1'b0;
        rvec();
        rvec();
        chk("t3_stall_ready", if_u.in_ready, 0);
        chk("t3_bank_valid", if_u.out_valid, 1);
        fork
            rvec();
            begin
                repeat (5) step();
                chk("t3_row_held", if_u.result_row, 0);
                or_dir = 1'b1;
            end
        join
        drain();

        // Same-cycle reload: gapless output across vectors
        fork
            repeat (3) rvec();
            begin
                wait_valid("t4_wait_timeout");
                for (int i = 0; i < 3 * M; i++) begin
                    chk("t4_gapless", if_u.out_valid, 1);
                    chk("t4_row_seq", if_u.result_row, i % M);
                    step();
                end
            end
        join
        drain();

        // clr mid-product with a loaded bank
        or_dir = 1'b0;
        rvec();
        repeat (2) beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        clr = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("t5_clr_ready_u", if_u.in_ready, 0);
        chk("t5_clr_ready_s", if_s.in_ready, 0);
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("t5_bank_kept", if_u.out_valid, 1);
        rvec();
        drain();

        // Asynchronous reset during a drain
        or_dir = 1'b1;
        rvec();
        wait_valid("t6_wait_timeout");
        step();
        #2 rst = 1'b0;
        #1;
        chk("t6_valid_u", if_u.out_valid, 0);
        chk("t6_valid_s", if_s.out_valid, 0);
        chk("t6_result_u", if_u.result, 0);
        chk("t6_result_s", if_s.result, 0);
        chk("t6_row", if_u.result_row, 0);
        chk("t6_last", if_u.out_last, 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_no_stale", if_u.out_valid, 0);
        rvec();
        drain();

        // Randomized traffic with random backpressure, gaps and occasional clr
        or_rand = 1'b1;
        repeat (150) begin
            if ($urandom_range(0, 29) == 0) begin
                clr = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                step();
                clr = 1'b0;
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) step();
            beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drain();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
